// File: rtl/guest_reset_pkg.sv
// Shared types and constants for the guest core reset sequencer.
package guest_reset_pkg;

    typedef enum logic [1:0] {
        ST_POR    = 2'd0,
        ST_ASSERT = 2'd1,
        ST_HOLD   = 2'd2,
        ST_RUN    = 2'd3
    } rst_state_e;

    localparam int CAUSE_PLL  = 0;
    localparam int CAUSE_USER = 1;
    localparam int CAUSE_CFG  = 2;
    localparam int CAUSE_DL   = 3;

    localparam logic [15:0] DL_RST_MASK_DEF = 16'h0002;

endpackage

// File: rtl/guest_reset_hold_cnt.sv
// Loadable down-counter for the reset hold window; saturates at 1 so it never underflows.
module guest_reset_hold_cnt #(
    parameter int HOLD_CYCLES = 64,
    parameter int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic load_i,
    input  logic dec_i,
    output logic is_one_o
);

    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CNT_W'(HOLD_CYCLES);
        end else if (dec_i && cnt_q > CNT_W'(1)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) cnt_q <= CNT_W'(HOLD_CYCLES);
        else            cnt_q <= cnt_d;
    end

    assign is_one_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/guest_reset_seq.sv
// Guest core reset sequencer: merges PLL/OSD/config/download causes into one minimum-width reset.
// Optional cause/count telemetry ports are built when GUEST_RST_CAUSE_EN is defined.
module guest_reset_seq
    import guest_reset_pkg::*;
#(
    parameter int          CFG_W       = 9,
    parameter int          HOLD_CYCLES = 64,
    parameter logic [15:0] DL_RST_MASK = DL_RST_MASK_DEF,
    parameter int          CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             pll_locked_i,
    input  logic             user_rst_i,
    input  logic [CFG_W-1:0] cfg_i,
    input  logic             dl_active_i,
    input  logic [7:0]       dl_index_i,
    output logic [CFG_W-1:0] cfg_o,
    output logic             core_reset_o,
    output logic             core_reset_n_o,
    output logic             cfg_changed_o
`ifdef GUEST_RST_CAUSE_EN
    ,
    output logic [3:0]       last_cause_o,
    output logic [7:0]       reset_count_o
`endif
);

    rst_state_e       state_d, state_q;
    logic [CFG_W-1:0] cfg_d, cfg_q;
    logic [CFG_W-1:0] cfg_out_d, cfg_out_q;
    logic             cfg_chg_d, cfg_chg_q;
    logic             core_rst_d, core_rst_q;
    logic             core_rst_n_d, core_rst_n_q;
    logic [3:0]       cause_vec;
    logic             cause;
    logic             cnt_load, cnt_dec, cnt_is_one;

    // Indexes 16+ are out of the mask's range and never force reset.
    always_comb begin
        cause_vec             = '0;
        cause_vec[CAUSE_PLL]  = ~pll_locked_i;
        cause_vec[CAUSE_USER] = user_rst_i;
        cause_vec[CAUSE_CFG]  = (cfg_i != cfg_q);
        cause_vec[CAUSE_DL]   = dl_active_i && (dl_index_i < 8'd16) &&
                                DL_RST_MASK[dl_index_i[3:0]];
        cause                 = |cause_vec;
    end

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b1;
        cnt_dec  = 1'b0;
        case (state_q)
            ST_POR:    state_d = ST_ASSERT;
            ST_ASSERT: if (!cause) state_d = ST_HOLD;
            ST_HOLD: begin
                if (cause) begin
                    state_d = ST_ASSERT;
                end else begin
                    cnt_load = 1'b0;
                    if (cnt_is_one) state_d = ST_RUN;
                    else            cnt_dec = 1'b1;
                end
            end
            ST_RUN:    if (cause) state_d = ST_ASSERT;
            default:   state_d = ST_POR;
        endcase
    end

    // cfg_o only follows cfg_q while the core is held, so the core never sees a live edit.
    always_comb begin
        cfg_d        = cfg_i;
        cfg_out_d    = cfg_out_q;
        cfg_chg_d    = 1'b0;
        core_rst_d   = (state_d != ST_RUN);
        core_rst_n_d = (state_d == ST_RUN);
        if ((state_q == ST_ASSERT || state_q == ST_HOLD) && cfg_q != cfg_out_q) begin
            cfg_out_d = cfg_q;
            cfg_chg_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= ST_POR;
            cfg_q        <= '0;
            cfg_out_q    <= '0;
            cfg_chg_q    <= 1'b0;
            core_rst_q   <= 1'b1;
            core_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cfg_q        <= cfg_d;
            cfg_out_q    <= cfg_out_d;
            cfg_chg_q    <= cfg_chg_d;
            core_rst_q   <= core_rst_d;
            core_rst_n_q <= core_rst_n_d;
        end
    end

    guest_reset_hold_cnt #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .CNT_W       (CNT_W)
    ) u_hold_cnt (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .load_i    (cnt_load),
        .dec_i     (cnt_dec),
        .is_one_o  (cnt_is_one)
    );

    assign cfg_o          = cfg_out_q;
    assign cfg_changed_o  = cfg_chg_q;
    assign core_reset_o   = core_rst_q;
    assign core_reset_n_o = core_rst_n_q;

`ifdef GUEST_RST_CAUSE_EN
    logic [3:0] last_cause_d, last_cause_q;
    logic [7:0] rst_cnt_d, rst_cnt_q;

    always_comb begin
        last_cause_d = last_cause_q;
        rst_cnt_d    = rst_cnt_q;
        if (state_d == ST_ASSERT && (state_q == ST_RUN || state_q == ST_POR)) begin
            last_cause_d = cause_vec;
        end
        if (state_q == ST_RUN && state_d == ST_ASSERT && rst_cnt_q != 8'hff) begin
            rst_cnt_d = rst_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            last_cause_q <= '0;
            rst_cnt_q    <= '0;
        end else begin
            last_cause_q <= last_cause_d;
            rst_cnt_q    <= rst_cnt_d;
        end
    end

    assign last_cause_o  = last_cause_q;
    assign reset_count_o = rst_cnt_q;
`endif

endmodule
